// File: rtl/cpu_execution_unit.sv
// Execution unit of the 16-bit processor.
// Holds the PC, the IR and an 8x16 register file, plus the ALU, the write-back mux
// and the memory-address mux. Each clock it applies one control word from the
// control unit. N/Z/C leave this block combinationally; the control unit latches them.
module cpu_execution_unit #(
    parameter int unsigned          DATA_W   = 16,
    parameter logic [DATA_W-1:0]    PC_RESET = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        W_Adr,
    input  logic [2:0]        R_Adr,
    input  logic [2:0]        S_Adr,
    input  logic              adr_sel,
    input  logic              s_sel,
    input  logic              pc_ld,
    input  logic              pc_inc,
    input  logic              pc_sel,
    input  logic              ir_ld,
    input  logic              mw_en,
    input  logic              rw_en,
    input  logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic [DATA_W-1:0] IR,
    output logic [DATA_W-1:0] PC,
    output logic              N,
    output logic              Z,
    output logic              C
);

    localparam int unsigned REG_N = 8;
    localparam int unsigned OFF_W = 8;
    localparam int unsigned EXT_W = DATA_W + 1;

    localparam logic [3:0] OP_PASS_S = 4'b0000;
    localparam logic [3:0] OP_PASS_R = 4'b0001;
    localparam logic [3:0] OP_INC_S  = 4'b0010;
    localparam logic [3:0] OP_DEC_S  = 4'b0011;
    localparam logic [3:0] OP_ADD    = 4'b0100;
    localparam logic [3:0] OP_SUB    = 4'b0101;
    localparam logic [3:0] OP_SHR    = 4'b0110;
    localparam logic [3:0] OP_SHL    = 4'b0111;
    localparam logic [3:0] OP_CMP    = 4'b1000;
    localparam logic [3:0] OP_AND    = 4'b1001;
    localparam logic [3:0] OP_OR     = 4'b1010;
    localparam logic [3:0] OP_XOR    = 4'b1011;
    localparam logic [3:0] OP_NOT_S  = 4'b1100;

    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_rf [REG_N];

    logic [DATA_W-1:0] w_r;
    logic [DATA_W-1:0] w_s;
    logic [EXT_W-1:0]  w_sum;
    logic [EXT_W-1:0]  w_diff;
    logic [EXT_W-1:0]  w_inc;
    logic [EXT_W-1:0]  w_dec;
    logic [DATA_W-1:0] w_y;
    logic              w_c;
    logic [DATA_W-1:0] w_wb;
    logic [DATA_W-1:0] w_off;

    // Asynchronous read ports; a same-cycle write is not forwarded.
    assign w_r = r_rf[R_Adr];
    assign w_s = r_rf[S_Adr];

    // Widened arithmetic so bit DATA_W carries the carry-out or the borrow.
    assign w_sum  = {1'b0, w_r} + {1'b0, w_s};
    assign w_diff = {1'b0, w_r} - {1'b0, w_s};
    assign w_inc  = {1'b0, w_s} + EXT_W'(1);
    assign w_dec  = {1'b0, w_s} - EXT_W'(1);

    // ALU result and carry/borrow selection.
    always_comb begin
        w_y = '0;
        w_c = 1'b0;
        case (alu_op)
            OP_PASS_S: w_y = w_s;
            OP_PASS_R: w_y = w_r;
            OP_INC_S: begin
                w_y = w_inc[DATA_W-1:0];
                w_c = w_inc[DATA_W];
            end
            OP_DEC_S: begin
                w_y = w_dec[DATA_W-1:0];
                w_c = w_dec[DATA_W];
            end
            OP_ADD: begin
                w_y = w_sum[DATA_W-1:0];
                w_c = w_sum[DATA_W];
            end
            OP_SUB, OP_CMP: begin
                w_y = w_diff[DATA_W-1:0];
                w_c = w_diff[DATA_W];
            end
            OP_SHR: begin
                w_y = {1'b0, w_s[DATA_W-1:1]};
                w_c = w_s[0];
            end
            OP_SHL: begin
                w_y = {w_s[DATA_W-2:0], 1'b0};
                w_c = w_s[DATA_W-1];
            end
            OP_AND:   w_y = w_r & w_s;
            OP_OR:    w_y = w_r | w_s;
            OP_XOR:   w_y = w_r ^ w_s;
            OP_NOT_S: w_y = ~w_s;
            default: begin
                w_y = '0;
                w_c = 1'b0;
            end
        endcase
    end

    assign N = w_y[DATA_W-1];
    assign Z = (w_y == '0);
    assign C = w_c;

    // Write-back source: memory data or ALU result.
    assign w_wb = s_sel ? mem_rdata : w_y;

    // Sign-extended branch offset taken from the current IR.
    assign w_off = {{(DATA_W-OFF_W){r_ir[OFF_W-1]}}, r_ir[OFF_W-1:0]};

    assign mem_addr  = adr_sel ? w_r : r_pc;
    assign mem_wdata = w_s;
    assign mem_we    = mw_en;
    assign IR        = r_ir;
    assign PC        = r_pc;

    // Program counter: reset, then load (relative or register), then increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= PC_RESET;
        end else if (pc_ld) begin
            r_pc <= pc_sel ? w_s : (r_pc + w_off);
        end else if (pc_inc) begin
            r_pc <= r_pc + DATA_W'(1);
        end
    end

    // Instruction register captures memory read data on ir_ld.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ir <= '0;
        end else if (ir_ld) begin
            r_ir <= mem_rdata;
        end
    end

    // Register file write port; every entry is writable.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REG_N; i++) begin
                r_rf[i] <= '0;
            end
        end else if (rw_en) begin
            r_rf[W_Adr] <= w_wb;
        end
    end

endmodule

// File: tb/tb_cpu_execution_unit.sv
// Self-checking bench for cpu_execution_unit: ALU vector table plus datapath sequences.
module tb_cpu_execution_unit;

    logic        clk;
    logic        reset;
    logic [2:0]  W_Adr, R_Adr, S_Adr;
    logic        adr_sel, s_sel, pc_ld, pc_inc, pc_sel, ir_ld, mw_en, rw_en;
    logic [3:0]  alu_op;
    logic [15:0] mem_rdata;
    logic [15:0] mem_addr, mem_wdata, IR, PC;
    logic        mem_we, N, Z, C;

    cpu_execution_unit #(.DATA_W(16), .PC_RESET(16'h0000)) dut (
        .clk(clk), .reset(reset),
        .W_Adr(W_Adr), .R_Adr(R_Adr), .S_Adr(S_Adr),
        .adr_sel(adr_sel), .s_sel(s_sel), .pc_ld(pc_ld), .pc_inc(pc_inc),
        .pc_sel(pc_sel), .ir_ld(ir_ld), .mw_en(mw_en), .rw_en(rw_en),
        .alu_op(alu_op), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .IR(IR), .PC(PC), .N(N), .Z(Z), .C(C)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int K_PC = 0, K_IR = 1, K_ADDR = 2, K_WDATA = 3,
                   K_WE = 4, K_N = 5, K_Z = 6, K_C = 7;

    typedef struct {
        int          kind;
        logic [15:0] exp;
        string       name;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] r;
        logic [15:0] s;
        logic [15:0] y;
        logic        n;
        logic        z;
        logic        c;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[17];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [15:0] actual(int kind);
        case (kind)
            K_PC:    return PC;
            K_IR:    return IR;
            K_ADDR:  return mem_addr;
            K_WDATA: return mem_wdata;
            K_WE:    return {15'b0, mem_we};
            K_N:     return {15'b0, N};
            K_Z:     return {15'b0, Z};
            default: return {15'b0, C};
        endcase
    endfunction

    task automatic push(int kind, logic [15:0] v, string nm);
        exp_t e;
        e.kind = kind;
        e.exp  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    // Pop every pending expectation and compare against the DUT.
    task automatic check_all();
        exp_t        e;
        logic [15:0] act;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            act = actual(e.kind);
            n_checks++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
    endtask

    task automatic drive_idle();
        reset = 1'b0; W_Adr = 3'd0; R_Adr = 3'd0; S_Adr = 3'd0;
        adr_sel = 1'b0; s_sel = 1'b0; pc_ld = 1'b0; pc_inc = 1'b0;
        pc_sel = 1'b0; ir_ld = 1'b0; mw_en = 1'b0; rw_en = 1'b0;
        alu_op = 4'd0; mem_rdata = 16'h0000;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_reg(logic [2:0] a, logic [15:0] v);
        drive_idle();
        s_sel = 1'b1; rw_en = 1'b1; W_Adr = a; mem_rdata = v;
        tick();
        drive_idle();
    endtask

    task automatic expect_reg(logic [2:0] a, logic [15:0] v, string nm);
        S_Adr = a;
        #1;
        push(K_WDATA, v, nm);
        check_all();
    endtask

    // Jump via R7 to place an arbitrary PC value.
    task automatic set_pc(logic [15:0] v);
        load_reg(3'd7, v);
        pc_ld = 1'b1; pc_sel = 1'b1; S_Adr = 3'd7;
        tick();
        drive_idle();
    endtask

    initial begin
        vecs[0]  = '{4'b0100, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b1, 1'b1};
        vecs[1]  = '{4'b0101, 16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{4'b0000, 16'h1234, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{4'b0001, 16'h8001, 16'h5555, 16'h8001, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{4'b0010, 16'h0000, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{4'b0011, 16'h0000, 16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{4'b0110, 16'h0000, 16'h8003, 16'h4001, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{4'b0111, 16'h0000, 16'hC001, 16'h8002, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{4'b1001, 16'hF0F0, 16'hFF00, 16'hF000, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{4'b1010, 16'hF0F0, 16'h0F0F, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{4'b1011, 16'hAAAA, 16'hAAAA, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{4'b1100, 16'h0000, 16'h00FF, 16'hFF00, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{4'b1101, 16'h0001, 16'h0001, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{4'b1111, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{4'b0100, 16'h7FFF, 16'h0001, 16'h8000, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{4'b0101, 16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{4'b1000, 16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b1, 1'b0};

        // Power-on reset.
        drive_idle();
        reset = 1'b1;
        tick();
        tick();
        drive_idle();
        #1;
        push(K_PC, 16'h0000, "reset_pc");
        push(K_IR, 16'h0000, "reset_ir");
        push(K_Z, 16'h0001, "reset_z");
        push(K_WE, 16'h0000, "reset_we");
        check_all();
        for (int i = 0; i < 8; i++) expect_reg(3'(i), 16'h0000, "reset_reg");

        // ALU vector table: R1/R2 operands, result written to R3 and read back.
        for (int i = 0; i < 17; i++) begin
            load_reg(3'd1, vecs[i].r);
            load_reg(3'd2, vecs[i].s);
            R_Adr = 3'd1; S_Adr = 3'd2; W_Adr = 3'd3;
            alu_op = vecs[i].op; rw_en = 1'b1;
            #1;
            push(K_N, {15'b0, vecs[i].n}, "alu_n");
            push(K_Z, {15'b0, vecs[i].z}, "alu_z");
            push(K_C, {15'b0, vecs[i].c}, "alu_c");
            check_all();
            tick();
            drive_idle();
            expect_reg(3'd3, vecs[i].y, "alu_y");
        end

        // Compare with rw_en=0 leaves the destination untouched.
        load_reg(3'd3, 16'h1234);
        load_reg(3'd1, 16'h0003);
        load_reg(3'd2, 16'h0005);
        R_Adr = 3'd1; S_Adr = 3'd2; W_Adr = 3'd3; alu_op = 4'b1000;
        #1;
        push(K_N, 16'h0001, "cmp_n");
        push(K_Z, 16'h0000, "cmp_z");
        push(K_C, 16'h0001, "cmp_c");
        check_all();
        tick();
        drive_idle();
        expect_reg(3'd3, 16'h1234, "cmp_no_write");

        // Same-cycle read returns the old value, new value next cycle.
        load_reg(3'd1, 16'h1111);
        s_sel = 1'b1; rw_en = 1'b1; W_Adr = 3'd1; mem_rdata = 16'h2222; S_Adr = 3'd1;
        #1;
        push(K_WDATA, 16'h1111, "raw_old");
        check_all();
        tick();
        push(K_WDATA, 16'h2222, "raw_new");
        check_all();
        drive_idle();

        // Fetch cycle.
        set_pc(16'h0010);
        ir_ld = 1'b1; pc_inc = 1'b1; mem_rdata = 16'hE0C8;
        #1;
        push(K_ADDR, 16'h0010, "fetch_addr");
        check_all();
        push(K_IR, 16'hE0C8, "fetch_ir");
        push(K_PC, 16'h0011, "fetch_pc");
        tick();
        check_all();
        drive_idle();

        // Idle control word holds PC and IR.
        push(K_PC, 16'h0011, "idle_pc");
        push(K_IR, 16'hE0C8, "idle_ir");
        tick();
        check_all();

        // Relative branch that wraps below zero, then increment wraps back.
        ir_ld = 1'b1; mem_rdata = 16'h00FE;
        tick();
        drive_idle();
        set_pc(16'h0001);
        pc_ld = 1'b1; pc_sel = 1'b0;
        push(K_PC, 16'hFFFF, "branch_wrap");
        tick();
        check_all();
        drive_idle();
        pc_inc = 1'b1;
        push(K_PC, 16'h0000, "inc_wrap");
        tick();
        check_all();
        drive_idle();

        // Branch with ir_ld and pc_inc together: old IR offset, pc_ld wins.
        pc_ld = 1'b1; pc_inc = 1'b1; ir_ld = 1'b1; mem_rdata = 16'h0005;
        push(K_PC, 16'hFFFE, "branch_old_ir");
        push(K_IR, 16'h0005, "branch_ir_ld");
        tick();
        check_all();
        drive_idle();

        // Store, load, register jump.
        load_reg(3'd4, 16'h0200);
        load_reg(3'd5, 16'hBEEF);
        adr_sel = 1'b1; R_Adr = 3'd4; S_Adr = 3'd5; mw_en = 1'b1;
        #1;
        push(K_ADDR, 16'h0200, "store_addr");
        push(K_WDATA, 16'hBEEF, "store_wdata");
        push(K_WE, 16'h0001, "store_we");
        check_all();
        tick();
        drive_idle();
        s_sel = 1'b1; rw_en = 1'b1; W_Adr = 3'd6; mem_rdata = 16'hBEEF;
        tick();
        drive_idle();
        expect_reg(3'd6, 16'hBEEF, "load_r6");
        pc_ld = 1'b1; pc_sel = 1'b1; S_Adr = 3'd4;
        push(K_PC, 16'h0200, "jump_pc");
        tick();
        check_all();
        drive_idle();

        // Reset mid-run beats every enable.
        set_pc(16'h0042);
        push(K_PC, 16'h0042, "pre_reset_pc");
        check_all();
        reset = 1'b1; pc_inc = 1'b1; rw_en = 1'b1; s_sel = 1'b1;
        W_Adr = 3'd2; mem_rdata = 16'hFFFF; ir_ld = 1'b1; pc_ld = 1'b1;
        push(K_PC, 16'h0000, "midreset_pc");
        push(K_IR, 16'h0000, "midreset_ir");
        tick();
        check_all();
        drive_idle();
        for (int i = 0; i < 8; i++) expect_reg(3'(i), 16'h0000, "midreset_reg");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_execution_unit.md
Name: cpu_execution_unit

Overview:
- Datapath that consumes the control word issued by the control unit (cu) of the 16-bit processor.
- Holds PC, IR and an 8x16 register file, plus the ALU, write-back mux and memory-address mux.
- Drives the memory interface and returns IR and the combinational N/Z/C status to the control unit, which latches the flags.
- One control word per clock; all architectural state updates on the rising edge of clk.

Parameters:
- DATA_W, 16, width of registers, PC, IR, ALU and memory data; address width equals DATA_W.
- PC_RESET, 16'h0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears state at the next rising edge.
- W_Adr  in  3  register-file write address.
- R_Adr  in  3  register-file R read port address.
- S_Adr  in  3  register-file S read port address.
- adr_sel  in  1  memory address select: 0 = PC, 1 = R[R_Adr].
- s_sel  in  1  write-back select: 0 = ALU result, 1 = mem_rdata.
- pc_ld  in  1  PC load enable.
- pc_inc  in  1  PC increment enable.
- pc_sel  in  1  PC load source: 0 = PC + sext(IR[7:0]), 1 = R[S_Adr].
- ir_ld  in  1  IR load from mem_rdata.
- mw_en  in  1  memory write enable.
- rw_en  in  1  register-file write enable.
- alu_op  in  4  ALU operation.
- mem_rdata  in  DATA_W  memory read data.
- mem_addr  out  DATA_W  memory address.
- mem_wdata  out  DATA_W  memory write data, equal to R[S_Adr].
- mem_we  out  1  equal to mw_en.
- IR  out  DATA_W  instruction register.
- PC  out  DATA_W  program counter.
- N, Z, C  out  1 each  combinational ALU status.

Behaviour:
- Reset at the next rising edge with reset=1:
  - PC=PC_RESET, IR=0, R0..R7=0.
  - Reset has priority over every enable and aborts any operation in progress.
  - Combinational outputs follow the reset state.
- Read ports are asynchronous: R=R[R_Adr], S=R[S_Adr].
- Register write is synchronous when rw_en=1: R[W_Adr] <= (s_sel ? mem_rdata : Y).
- Same-cycle read of W_Adr returns the old value; the new value is visible the next cycle.
- All 8 registers are writable; none is hardwired.
- ALU result Y is 16-bit, computed combinationally from R and S:
  - 0000: Y=S, C=0.
  - 0001: Y=R, C=0.
  - 0010: Y=S+1, C=carry-out.
  - 0011: Y=S-1, C=borrow.
  - 0100: Y=R+S, C=carry-out of the 17-bit sum.
  - 0101: Y=R-S, C=borrow (1 when R<S unsigned).
  - 0110: Y=S>>1 logical, C=S[0].
  - 0111: Y=S<<1, C=S[15].
  - 1000: compare; Y=R-S, C=borrow; Y is identical to op 0101 and is written only if rw_en=1.
  - 1001: Y=R&S, C=0.
  - 1010: Y=R|S, C=0.
  - 1011: Y=R^S, C=0.
  - 1100: Y=~S, C=0.
  - 1101-1111: Y=0, C=0.
- Flags: N=Y[15], Z=(Y==0), computed for every op. The flags are zero-latency combinational outputs; the execution unit does not register them.
- Memory address: mem_addr = adr_sel ? R[R_Adr] : PC.
- Memory write: mem_we=mw_en, mem_wdata=R[S_Adr]. Memory samples these on the same edge.
- PC update priority is reset > pc_ld > pc_inc:
  - pc_ld & !pc_sel: PC <= PC + sext(IR[7:0]), computed mod 2^16.
  - pc_ld & pc_sel: PC <= R[S_Adr].
  - else if pc_inc: PC <= PC+1; 16'hFFFF wraps to 16'h0000.
  - else PC holds.
- Branch offset is relative to the PC value present when pc_ld is asserted, i.e. already incremented past the instruction.
- IR update: ir_ld=1 gives IR <= mem_rdata. Otherwise IR holds.
- Fetch cycle (ir_ld=1, pc_inc=1, adr_sel=0): IR captures M[old PC] and PC becomes old PC+1 on the same edge.
- Immediate-load cycle (s_sel=1, adr_sel=0, pc_inc=1, rw_en=1): R[W_Adr] <= M[PC] and PC <= PC+1 on the same edge.
- Simultaneous rw_en and mw_en are legal and independent.
- ir_ld together with pc_ld is legal. The PC branch computation uses the old IR.
- All-zero control word: no state change.

Test Plan:
- Reset mid-run: assert reset with pc_inc=1, rw_en=1, PC=16'h0042 -> next edge PC=0000, IR=0, all registers 0.
- Fetch: PC=0010, mem_rdata=E0C8, ir_ld=pc_inc=1 -> mem_addr=0010; after edge IR=E0C8, PC=0011.
- ADD with carry: R1=FFFF, R2=0001, R_Adr=1, S_Adr=2, W_Adr=3, alu_op=0100, rw_en=1 -> N=0, Z=1, C=1 during cycle; R3=0000 after edge.
- Compare: R1=0003, R2=0005, alu_op=1000, rw_en=0 -> Y=FFFE, N=1, Z=0, C=1; no register changes.
- Relative branch with wrap: PC=0001, IR[7:0]=FE, pc_ld=1, pc_sel=0 -> PC=FFFF; then pc_inc=1 -> PC=0000.
- Store/load/jump, in order:
  - R4=0200, R5=BEEF; adr_sel=1, R_Adr=4, S_Adr=5, mw_en=1 -> mem_addr=0200, mem_wdata=BEEF, mem_we=1.
  - Then s_sel=1, rw_en=1, W_Adr=6, mem_rdata=BEEF -> R6=BEEF.
  - Then pc_ld=pc_sel=1, S_Adr=4 -> PC=0200.
